wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 121 ++++++++++++
 tb/tb_wb_regfile.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and architectural state for the 8-bit datapath.
// Holds an NUM_REGS x DATA_W register file, the {c,n,z} flag register,
// two combinational read ports, and a "clear all" sequencer. Writeback
// is stalled while the clear sequence runs.
// Optional build macro: WB_BYPASS_EN adds write-through forwarding so a
// writeback being accepted is visible on the read ports and flags in the
// same cycle.
module wb_regfile #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int FLAG_W   = 3,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [FLAG_W-1:0] wb_flags,
  input  logic              wb_reg_we,
  input  logic              wb_flag_we,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [FLAG_W-1:0] flags_q,
  output logic              cin_q,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              accept;

  assign wb_ready = (state_q == IDLE);
  assign clr_busy = (state_q == CLEAR);
  assign accept   = wb_valid && wb_ready;

  // Next-state: writeback commit in IDLE, one register zeroed per cycle in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (accept && wb_reg_we)  regs_d[wb_rd] = wb_data;
        if (accept && wb_flag_we) flag_d = wb_flags;
        // A writeback in the same cycle as clr_req still lands; the clear wipes it later.
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        if (cnt_q == '0) flag_d = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, register array and flags; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef WB_BYPASS_EN
  // Forward an accepted writeback straight to the read ports and flag output.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    flags_q = flag_q;
    if (accept && wb_reg_we && (ra_addr == wb_rd)) ra_data = wb_data;
    if (accept && wb_reg_we && (rb_addr == wb_rd)) rb_data = wb_data;
    if (accept && wb_flag_we)                      flags_q = wb_flags;
  end
`else
  // Read ports and flags reflect stored state only (one-cycle write latency).
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    flags_q = flag_q;
  end
`endif

  // Carry-in to the ALU is the c bit, the MSB of {c,n,z}.
  assign cin_q = flags_q[FLAG_W-1];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run, all checked against a behavioural model of the register file.
module tb_wb_regfile;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int FLAG_W   = 3;
  localparam int ADDR_W   = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [FLAG_W-1:0] wb_flags;
  logic              wb_reg_we;
  logic              wb_flag_we;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [FLAG_W-1:0] flags_q;
  logic              cin_q;
  logic              clr_req;
  logic              clr_busy;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: register contents, flags, and how far a clear has progressed.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [FLAG_W-1:0] m_flags;
  bit                m_busy;
  int                m_clr_idx;

  wb_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
    .wb_reg_we(wb_reg_we), .wb_flag_we(wb_flag_we),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .flags_q(flags_q), .cin_q(cin_q),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_flags   = '0;
    m_busy    = 0;
    m_clr_idx = 0;
  endtask

  // Apply the architectural rules for one rising edge using the current inputs.
  task automatic m_edge();
    if (!reset_n) begin
      m_reset();
    end else if (!m_busy) begin
      if (wb_valid && wb_reg_we)  m_regs[wb_rd] = wb_data;
      if (wb_valid && wb_flag_we) m_flags = wb_flags;
      if (clr_req) begin
        m_busy    = 1;
        m_clr_idx = 0;
      end
    end else begin
      m_regs[m_clr_idx] = '0;
      if (m_clr_idx == 0) m_flags = '0;
      m_clr_idx++;
      if (m_clr_idx == NUM_REGS) begin
        m_busy    = 0;
        m_clr_idx = 0;
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
`ifdef WB_BYPASS_EN
    if (reset_n && wb_valid && !m_busy && wb_reg_we && a == wb_rd) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [FLAG_W-1:0] exp_flags();
`ifdef WB_BYPASS_EN
    if (reset_n && wb_valid && !m_busy && wb_flag_we) return wb_flags;
`endif
    return m_flags;
  endfunction

  // One clock: model updates at the edge, then inputs may change 2 units later.
  task automatic step();
    @(posedge clk);
    m_edge();
    #2;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = '0; wb_data = '0; wb_flags = '0;
    wb_reg_we = 0; wb_flag_we = 0; clr_req = 0;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    wb_valid = 1; wb_rd = rd; wb_data = d; wb_reg_we = 1; wb_flag_we = 0;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    ra_addr = '0; rb_addr = '0;
    reset_n = 0;
    m_reset();
    #1;
    n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", wb_ready); end
    step(); step();
    reset_n = 1;
    #1;
    n_vec++; if (flags_q !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", flags_q); end
    n_vec++; if (cin_q !== 1'b0) begin n_err++; $display("FAIL reset_cin: got %b expected 0", cin_q); end
    n_vec++; if (wb_ready !== 1'b1 || clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: ready %b busy %b expected 1 0", wb_ready, clr_busy); end
    for (int i = 0; i < NUM_REGS; i++) begin
      ra_addr = ADDR_W'(i); rb_addr = ADDR_W'(NUM_REGS - 1 - i);
      #1;
      n_vec++; if (ra_data !== 8'h00 || rb_data !== 8'h00) begin n_err++; $display("FAIL reset_read[%0d]: ra %h rb %h expected 00 00", i, ra_data, rb_data); end
    end
  endtask

  task automatic test_write_read();
    ra_addr = 3'd3; rb_addr = 3'd3;
    wb_valid = 1; wb_rd = 3'd3; wb_data = 8'hA5; wb_reg_we = 1; wb_flag_we = 0;
    #1;
    n_vec++; if (ra_data !== exp_read(3'd3)) begin n_err++; $display("FAIL wr_same_cycle: got %h expected %h", ra_data, exp_read(3'd3)); end
    step();
    idle_inputs();
    #1;
    n_vec++; if (ra_data !== 8'hA5) begin n_err++; $display("FAIL wr_port_a: got %h expected a5", ra_data); end
    n_vec++; if (rb_data !== 8'hA5) begin n_err++; $display("FAIL wr_port_b: got %h expected a5", rb_data); end
    n_vec++; if (flags_q !== 3'b000) begin n_err++; $display("FAIL wr_flags_kept: got %b expected 000", flags_q); end
  endtask

  task automatic test_flags();
    ra_addr = 3'd2;
    wb_valid = 1; wb_rd = 3'd2; wb_data = 8'hEE; wb_flags = 3'b101; wb_reg_we = 0; wb_flag_we = 1;
    step();
    idle_inputs();
    #1;
    n_vec++; if (flags_q !== 3'b101) begin n_err++; $display("FAIL flags_val: got %b expected 101", flags_q); end
    n_vec++; if (cin_q !== 1'b1) begin n_err++; $display("FAIL flags_cin: got %b expected 1", cin_q); end
    n_vec++; if (ra_data !== 8'h00) begin n_err++; $display("FAIL flags_reg2_kept: got %h expected 00", ra_data); end
  endtask

  task automatic test_clear();
    logic [DATA_W-1:0] nxt;
    for (int i = 0; i < NUM_REGS; i++) write_reg(ADDR_W'(i), 8'h10 + 8'(i));
    wb_valid = 1; wb_flags = 3'b111; wb_flag_we = 1; wb_reg_we = 0;
    step();
    idle_inputs();
    // Writeback coinciding with clr_req is accepted, then wiped by the clear.
    clr_req = 1; wb_valid = 1; wb_rd = 3'd6; wb_data = 8'h99; wb_reg_we = 1;
    step();
    idle_inputs();
    ra_addr = 3'd6;
    #1;
    n_vec++; if (ra_data !== 8'h99) begin n_err++; $display("FAIL clr_same_cycle_wr: got %h expected 99", ra_data); end
    n_vec++; if (flags_q !== 3'b111) begin n_err++; $display("FAIL clr_flags_before: got %b expected 111", flags_q); end
    for (int k = 0; k < NUM_REGS; k++) begin
      ra_addr = ADDR_W'(k); rb_addr = ADDR_W'((k + 1) % NUM_REGS);
      #1;
      n_vec++; if (clr_busy !== 1'b1 || wb_ready !== 1'b0) begin n_err++; $display("FAIL clr_busy[%0d]: busy %b ready %b expected 1 0", k, clr_busy, wb_ready); end
      step();
      #1;
      n_vec++; if (ra_data !== 8'h00) begin n_err++; $display("FAIL clr_reg[%0d]: got %h expected 00", k, ra_data); end
      if (k == 0) begin
        n_vec++; if (flags_q !== 3'b000) begin n_err++; $display("FAIL clr_flags: got %b expected 000", flags_q); end
      end
      if (k < NUM_REGS - 1) begin
        nxt = (k + 1 == 6) ? 8'h99 : 8'h10 + 8'(k + 1);
        n_vec++; if (rb_data !== nxt) begin n_err++; $display("FAIL clr_next[%0d]: got %h expected %h", k, rb_data, nxt); end
      end
    end
    #1;
    n_vec++; if (clr_busy !== 1'b0 || wb_ready !== 1'b1) begin n_err++; $display("FAIL clr_done: busy %b ready %b expected 0 1", clr_busy, wb_ready); end
    for (int i = 0; i < NUM_REGS; i++) begin
      ra_addr = ADDR_W'(i);
      #1;
      n_vec++; if (ra_data !== 8'h00) begin n_err++; $display("FAIL clr_final[%0d]: got %h expected 00", i, ra_data); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < NUM_REGS; i++) write_reg(ADDR_W'(i), 8'h10 + 8'(i));
    clr_req = 1;
    step();
    idle_inputs();
    wb_valid = 1; wb_rd = 3'd5; wb_data = 8'h3C; wb_reg_we = 1;
    ra_addr = 3'd5;
    for (int k = 0; k < NUM_REGS; k++) begin
      clr_req = (k == 4);
      #1;
      n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b expected 0", k, wb_ready); end
      n_vec++; if (ra_data !== exp_read(3'd5)) begin n_err++; $display("FAIL stall_reg5[%0d]: got %h expected %h", k, ra_data, exp_read(3'd5)); end
      step();
    end
    clr_req = 0;
    #1;
    n_vec++; if (clr_busy !== 1'b0 || wb_ready !== 1'b1) begin n_err++; $display("FAIL stall_no_extend: busy %b ready %b expected 0 1", clr_busy, wb_ready); end
    step();
    idle_inputs();
    #1;
    n_vec++; if (ra_data !== 8'h3C) begin n_err++; $display("FAIL stall_accept: got %h expected 3c", ra_data); end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < NUM_REGS; i++) write_reg(ADDR_W'(i), 8'hC0 + 8'(i));
    wb_valid = 1; wb_flags = 3'b110; wb_flag_we = 1;
    step();
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    step(); step(); step();
    #1;
    n_vec++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", clr_busy); end
    reset_n = 0;
    m_reset();
    #1;
    n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_async: got %b expected 0", clr_busy); end
    n_vec++; if (flags_q !== 3'b000 || cin_q !== 1'b0) begin n_err++; $display("FAIL mid_flags: got %b/%b expected 000/0", flags_q, cin_q); end
    for (int i = 0; i < NUM_REGS; i++) begin
      ra_addr = ADDR_W'(i); rb_addr = ADDR_W'(i);
      #1;
      n_vec++; if (ra_data !== 8'h00 || rb_data !== 8'h00) begin n_err++; $display("FAIL mid_read[%0d]: ra %h rb %h expected 00 00", i, ra_data, rb_data); end
    end
    step();
    reset_n = 1;
    #1;
    n_vec++; if (wb_ready !== 1'b1 || clr_busy !== 1'b0) begin n_err++; $display("FAIL mid_release: ready %b busy %b expected 1 0", wb_ready, clr_busy); end
  endtask

  task automatic test_random();
    logic [FLAG_W-1:0] ef;
    for (int c = 0; c < 400; c++) begin
      wb_valid   = ($urandom_range(0, 3) != 0);
      wb_rd      = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wb_data    = DATA_W'($urandom);
      wb_flags   = FLAG_W'($urandom);
      wb_reg_we  = $urandom_range(0, 1) != 0;
      wb_flag_we = $urandom_range(0, 2) == 0;
      ra_addr    = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rb_addr    = ($urandom_range(0, 3) == 0) ? ra_addr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      clr_req    = ($urandom_range(0, 29) == 0);
      #1;
      ef = exp_flags();
      n_vec++; if (ra_data !== exp_read(ra_addr)) begin n_err++; $display("FAIL rnd_ra[%0d]: got %h expected %h", c, ra_data, exp_read(ra_addr)); end
      n_vec++; if (rb_data !== exp_read(rb_addr)) begin n_err++; $display("FAIL rnd_rb[%0d]: got %h expected %h", c, rb_data, exp_read(rb_addr)); end
      n_vec++; if (flags_q !== ef) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b expected %b", c, flags_q, ef); end
      n_vec++; if (cin_q !== ef[2]) begin n_err++; $display("FAIL rnd_cin[%0d]: got %b expected %b", c, cin_q, ef[2]); end
      n_vec++; if (wb_ready !== !m_busy) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, wb_ready, !m_busy); end
      n_vec++; if (clr_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, clr_busy, m_busy); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_flags();
    test_clear();
    test_stall();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
